// File: rtl/cordic_step_sequencer.sv
// cordic_step_sequencer: after one start pulse, streams the per-iteration
// angle constant (delta_z) and shift index for a full CORDIC run in linear,
// circular or hyperbolic mode, over a valid/ready handshake.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; outputs quiet, err pulses on mode = 3
// S_RUN  | presenting a beat; advances only on out_valid && out_ready
module cordic_step_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int ITERATIONS  = 16,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  delta_z,
  output logic [SHIFT_WIDTH-1:0] shift,
  output logic                   last,
  output logic                   done,
  output logic                   err
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [1:0] M_LIN  = 2'd0;
  localparam logic [1:0] M_CIRC = 2'd1;
  localparam logic [1:0] M_HYP  = 2'd2;
  localparam logic [1:0] M_RSV  = 2'd3;

  // Q2.30 master values are reduced to Q2.(DATA_WIDTH-2) by a rounded right shift.
  localparam int          RED_SH   = 32 - DATA_WIDTH;
  localparam logic [32:0] RND_HALF = (RED_SH > 0) ? (33'd1 << ((RED_SH > 0) ? RED_SH - 1 : 0)) : 33'd0;

  // Q2.30 master table. Beyond i = 9 the cubic term of atan/atanh rounds away,
  // so both collapse onto the linear 2^-i entry.
  function automatic logic [31:0] master_angle(input logic [1:0] m, input logic [SHIFT_WIDTH-1:0] i);
    logic [31:0] pow2;
    pow2 = (int'(i) >= 31) ? 32'd1 : (32'h4000_0000 >> i);
    master_angle = pow2;
    if (m == M_CIRC) begin
      case (int'(i))
        0:       master_angle = 32'h3243_F6A9;
        1:       master_angle = 32'h1DAC_6705;
        2:       master_angle = 32'h0FAD_BAFD;
        3:       master_angle = 32'h07F5_6EA7;
        4:       master_angle = 32'h03FE_AB77;
        5:       master_angle = 32'h01FF_D55C;
        6:       master_angle = 32'h00FF_FAAB;
        7:       master_angle = 32'h007F_FF55;
        8:       master_angle = 32'h003F_FFEB;
        9:       master_angle = 32'h001F_FFFD;
        31:      master_angle = 32'h0000_0000;
        default: master_angle = pow2;
      endcase
    end else if (m == M_HYP) begin
      case (int'(i))
        0:       master_angle = 32'h0000_0000;  // atanh(1) diverges; never emitted
        1:       master_angle = 32'h2327_D4F5;
        2:       master_angle = 32'h1058_AEFB;
        3:       master_angle = 32'h080A_C48E;
        4:       master_angle = 32'h0401_5623;
        5:       master_angle = 32'h0200_2AB1;
        6:       master_angle = 32'h0100_0556;
        7:       master_angle = 32'h0080_00AB;
        8:       master_angle = 32'h0040_0015;
        9:       master_angle = 32'h0020_0003;
        default: master_angle = pow2;
      endcase
    end
  endfunction

  // Tiny angles still have to nudge z, so the constant never drops below 1 LSB.
  function automatic logic [DATA_WIDTH-1:0] step_angle(input logic [1:0] m, input logic [SHIFT_WIDTH-1:0] i);
    logic [DATA_WIDTH-1:0] r;
    r = DATA_WIDTH'(({1'b0, master_angle(m, i)} + RND_HALF) >> RED_SH);
    if ((int'(i) > DATA_WIDTH - 2) || (r == '0)) r = DATA_WIDTH'(1);
    return r;
  endfunction

  state_t                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [SHIFT_WIDTH-1:0] idx_q, idx_d;
  logic [SHIFT_WIDTH-1:0] beat_q, beat_d;
  logic [6:0]             rpt_q, rpt_d;
  logic                   dup_q, dup_d;
  logic                   busy_q, busy_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  delta_z_q, delta_z_d;
  logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
  logic                   last_q, last_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   hyp_rpt_hit;
  logic [SHIFT_WIDTH-1:0] nxt_idx;
  logic                   nxt_dup;
  logic [1:0]             step_mode;
  logic [SHIFT_WIDTH-1:0] step_idx;
  logic [DATA_WIDTH-1:0]  step_dz;

  // Next-state and next-beat computation; the beat that will be presented
  // after this edge is looked up here so every output leaves a flop.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    beat_d      = beat_q;
    rpt_d       = rpt_q;
    dup_d       = dup_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    delta_z_d   = delta_z_q;
    shift_d     = shift_q;
    last_d      = last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    // Hyperbolic convergence needs indices 4, 13, 40, ... (k -> 3k+1) twice.
    hyp_rpt_hit = (mode_q == M_HYP) && (int'(idx_q) == int'(rpt_q));
    nxt_idx     = idx_q + SHIFT_WIDTH'(1);
    nxt_dup     = 1'b0;
    if (hyp_rpt_hit && !dup_q) begin
      nxt_idx = idx_q;
      nxt_dup = 1'b1;
    end

    step_mode = mode_q;
    step_idx  = nxt_idx;
    if (state_q == S_IDLE) begin
      step_mode = mode;
      step_idx  = (mode == M_HYP) ? SHIFT_WIDTH'(1) : '0;
    end
    step_dz = step_angle(step_mode, step_idx);

    if (state_q == S_IDLE) begin
      if (start) begin
        if (mode == M_RSV) begin
          err_d = 1'b1;
        end else begin
          state_d     = S_RUN;
          mode_d      = mode;
          idx_d       = step_idx;
          beat_d      = '0;
          rpt_d       = 7'd4;
          dup_d       = 1'b0;
          busy_d      = 1'b1;
          out_valid_d = 1'b1;
          delta_z_d   = step_dz;
          shift_d     = step_idx;
          last_d      = (ITERATIONS == 1);
        end
      end
    end else if (out_valid_q && out_ready) begin
      if (last_q) begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        last_d      = 1'b0;
        done_d      = 1'b1;
      end else begin
        idx_d     = nxt_idx;
        dup_d     = nxt_dup;
        if (hyp_rpt_hit && dup_q) rpt_d = 7'(3 * int'(rpt_q) + 1);
        beat_d    = beat_q + SHIFT_WIDTH'(1);
        delta_z_d = step_dz;
        shift_d   = nxt_idx;
        last_d    = (int'(beat_q) + 1 == ITERATIONS - 1);
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= M_LIN;
      idx_q       <= '0;
      beat_q      <= '0;
      rpt_q       <= 7'd4;
      dup_q       <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      delta_z_q   <= '0;
      shift_q     <= '0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      beat_q      <= beat_d;
      rpt_q       <= rpt_d;
      dup_q       <= dup_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      delta_z_q   <= delta_z_d;
      shift_q     <= shift_d;
      last_q      <= last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign delta_z   = delta_z_q;
  assign shift     = shift_q;
  assign last      = last_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cordic_step_sequencer.sv
// Directed bench for cordic_step_sequencer (DATA_WIDTH = 16, ITERATIONS = 16).
module tb_cordic_step_sequencer;
  localparam int DW = 16;
  localparam int IT = 16;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          out_ready = 1'b1;
  logic          busy, out_valid, last, done, err;
  logic [DW-1:0] delta_z;
  logic [SW-1:0] shift;

  cordic_step_sequencer #(.DATA_WIDTH(DW), .ITERATIONS(IT), .SHIFT_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .delta_z(delta_z),
    .shift(shift), .last(last), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] rec_delta [32];
  logic [SW-1:0] rec_shift [32];
  logic          rec_last  [32];
  logic [DW-1:0] exp_delta [16];
  int            exp_shift [16];
  int            hyp_shift [16] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load_linear_exp();
    logic [DW-1:0] one_q2;
    one_q2 = 16'h4000;
    for (int b = 0; b < 16; b++) begin
      exp_shift[b] = b;
      exp_delta[b] = (b < 14) ? (one_q2 >> b) : 16'h0001;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Starts a run, records every handshaken beat, optionally holds out_ready low
  // for stall_len cycles at beat stall_at, optionally pokes start mid-run.
  // done_cyc counts cycles after the start edge (first beat appears at 1).
  task automatic do_run(input logic [1:0] m, input int stall_at, input int stall_len,
                        input bit poke, output int n_hs, output int done_cyc);
    int cyc;
    int held;
    cyc = 0;
    held = 0;
    n_hs = 0;
    done_cyc = -1;
    mode = m;
    start = 1'b1;
    out_ready = 1'b1;
    next_cycle();
    start = 1'b0;
    while (done_cyc < 0 && cyc < 100) begin
      cyc++;
      start = 1'b0;
      if (done) begin
        done_cyc = cyc;
      end else if (out_valid) begin
        if (n_hs == stall_at && held < stall_len) begin
          check_eq("stall_shift", 32'(shift), 32'(exp_shift[stall_at]));
          check_eq("stall_delta", 32'(delta_z), 32'(exp_delta[stall_at]));
          check_eq("stall_last", 32'(last), 32'd0);
          out_ready = 1'b0;
          held++;
        end else begin
          out_ready = 1'b1;
          if (n_hs < 32) begin
            rec_shift[n_hs] = shift;
            rec_delta[n_hs] = delta_z;
            rec_last[n_hs]  = last;
          end
          n_hs++;
          if (poke && n_hs == 3) begin
            start = 1'b1;
            mode = 2'd1;
          end
        end
      end
      if (done_cyc < 0) next_cycle();
    end
    out_ready = 1'b1;
    start = 1'b0;
    check_eq("done_seen", 32'(done_cyc >= 0), 32'd1);
  endtask

  initial begin
    int n_hs;
    int done_cyc;

    next_cycle();
    next_cycle();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_last", 32'(last), 32'd0);
    check_eq("rst_delta", 32'(delta_z), 32'd0);
    check_eq("rst_shift", 32'(shift), 32'd0);
    rst = 1'b0;
    next_cycle();

    // Linear run, ready held high.
    load_linear_exp();
    do_run(2'd0, -1, 0, 1'b0, n_hs, done_cyc);
    check_eq("lin_beats", 32'(n_hs), 32'd16);
    check_eq("lin_done_cyc", 32'(done_cyc), 32'd17);
    check_eq("lin_done_valid", 32'(out_valid), 32'd0);
    check_eq("lin_done_busy", 32'(busy), 32'd0);
    for (int b = 0; b < 16; b++) begin
      check_eq($sformatf("lin_shift%0d", b), 32'(rec_shift[b]), 32'(exp_shift[b]));
      check_eq($sformatf("lin_delta%0d", b), 32'(rec_delta[b]), 32'(exp_delta[b]));
      check_eq($sformatf("lin_last%0d", b), 32'(rec_last[b]), 32'(b == 15));
    end

    // Circular run started in the done cycle of the linear run (back-to-back).
    do_run(2'd1, -1, 0, 1'b0, n_hs, done_cyc);
    check_eq("circ_beats", 32'(n_hs), 32'd16);
    check_eq("circ_done_cyc", 32'(done_cyc), 32'd17);
    check_eq("circ_delta0", 32'(rec_delta[0]), 32'h3244);
    check_eq("circ_delta1", 32'(rec_delta[1]), 32'h1DAC);
    check_eq("circ_delta2", 32'(rec_delta[2]), 32'h0FAE);
    check_eq("circ_delta3", 32'(rec_delta[3]), 32'h07F5);
    for (int b = 0; b < 16; b++)
      check_eq($sformatf("circ_shift%0d", b), 32'(rec_shift[b]), 32'(b));
    next_cycle();
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("idle_valid", 32'(out_valid), 32'd0);

    // Hyperbolic run with repeat indices.
    do_run(2'd2, -1, 0, 1'b0, n_hs, done_cyc);
    check_eq("hyp_beats", 32'(n_hs), 32'd16);
    for (int b = 0; b < 16; b++) begin
      check_eq($sformatf("hyp_shift%0d", b), 32'(rec_shift[b]), 32'(hyp_shift[b]));
      check_eq($sformatf("hyp_last%0d", b), 32'(rec_last[b]), 32'(b == 15));
    end
    check_eq("hyp_delta0", 32'(rec_delta[0]), 32'h2328);
    check_eq("hyp_delta1", 32'(rec_delta[1]), 32'h1059);
    check_eq("hyp_delta3", 32'(rec_delta[3]), 32'h0401);
    check_eq("hyp_delta4", 32'(rec_delta[4]), 32'h0401);
    next_cycle();

    // Backpressure: 3 stalled cycles at beat 5.
    do_run(2'd0, 5, 3, 1'b0, n_hs, done_cyc);
    check_eq("bp_beats", 32'(n_hs), 32'd16);
    check_eq("bp_done_cyc", 32'(done_cyc), 32'd20);
    for (int b = 0; b < 16; b++)
      check_eq($sformatf("bp_delta%0d", b), 32'(rec_delta[b]), 32'(exp_delta[b]));
    next_cycle();

    // start poked mid-run is ignored.
    do_run(2'd0, -1, 0, 1'b1, n_hs, done_cyc);
    check_eq("poke_beats", 32'(n_hs), 32'd16);
    check_eq("poke_done_cyc", 32'(done_cyc), 32'd17);
    for (int b = 0; b < 16; b++)
      check_eq($sformatf("poke_delta%0d", b), 32'(rec_delta[b]), 32'(exp_delta[b]));
    check_eq("poke_err", 32'(err), 32'd0);
    next_cycle();
    check_eq("poke_no_rerun", 32'(out_valid), 32'd0);

    // Reserved mode.
    mode = 2'd3;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    mode = 2'd0;
    check_eq("rsv_err", 32'(err), 32'd1);
    check_eq("rsv_busy", 32'(busy), 32'd0);
    check_eq("rsv_valid", 32'(out_valid), 32'd0);
    next_cycle();
    check_eq("rsv_err_pulse", 32'(err), 32'd0);
    check_eq("rsv_valid2", 32'(out_valid), 32'd0);

    // Reset at beat 7.
    mode = 2'd0;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (7) next_cycle();
    check_eq("pre_rst_shift", 32'(shift), 32'd7);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    next_cycle();
    check_eq("mid_rst_done2", 32'(done), 32'd0);
    do_run(2'd0, -1, 0, 1'b0, n_hs, done_cyc);
    check_eq("rerun_beats", 32'(n_hs), 32'd16);
    check_eq("rerun_shift0", 32'(rec_shift[0]), 32'd0);
    check_eq("rerun_delta0", 32'(rec_delta[0]), 32'h4000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
